// File: rtl/vga_layer_scaled.sv
// Single-layer VGA address generator with integer pixel replication and shadowed
// configuration registers that swap into the active set only at end of frame.
module vga_layer_scaled #(
  parameter int ADDR_W  = 26,
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               hwregs_layer_select,
  input  logic [2:0]         hwregs_layer_addr,
  input  logic [ADDR_W-1:0]  hwregs_wdata,
  input  logic               p1_valid,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p1_y,
  input  logic               p1_end_of_frame,
  input  logic               p1_end_of_line,
  output logic [ADDR_W-1:0]  p2_addr,
  output logic               p2_valid
);

  logic [ADDR_W-1:0]  sh_addr, act_addr;
  logic [COORD_W-1:0] sh_x1, sh_y1, sh_x2, sh_y2, sh_bpl;
  logic [COORD_W-1:0] act_x1, act_y1, act_x2, act_y2, act_bpl;
  logic [1:0]         sh_bpp, act_bpp;
  logic               sh_en, act_en;
  logic [2:0]         sh_xsc, sh_ysc, act_xsc, act_ysc;

  logic [ADDR_W-1:0]  line_start, pix_next;
  logic [2:0]         xrep, yrep;

  logic               x_in, y_in, hit;
  logic [ADDR_W-1:0]  line_adv, pix_adv;

  // Software writes always land in the shadow set, even while the pipeline is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_addr <= '0;
      sh_x1   <= '0;
      sh_y1   <= '0;
      sh_x2   <= '0;
      sh_y2   <= '0;
      sh_bpl  <= '0;
      sh_bpp  <= '0;
      sh_en   <= 1'b0;
      sh_xsc  <= '0;
      sh_ysc  <= '0;
    end else if (hwregs_layer_select) begin
      case (hwregs_layer_addr)
        3'd0: sh_addr <= hwregs_wdata;
        3'd1: sh_x1   <= hwregs_wdata[COORD_W-1:0];
        3'd2: sh_y1   <= hwregs_wdata[COORD_W-1:0];
        3'd3: sh_x2   <= hwregs_wdata[COORD_W-1:0];
        3'd4: sh_y2   <= hwregs_wdata[COORD_W-1:0];
        3'd5: sh_bpl  <= hwregs_wdata[COORD_W-1:0];
        3'd6: sh_bpp  <= hwregs_wdata[1:0];
        3'd7: begin
          sh_en  <= hwregs_wdata[0];
          sh_xsc <= hwregs_wdata[3:1];
          sh_ysc <= hwregs_wdata[6:4];
        end
      endcase
    end
  end

  // The active set copies the pre-write shadow, so a same-cycle write waits a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_addr <= '0;
      act_x1   <= '0;
      act_y1   <= '0;
      act_x2   <= '0;
      act_y2   <= '0;
      act_bpl  <= '0;
      act_bpp  <= '0;
      act_en   <= 1'b0;
      act_xsc  <= '0;
      act_ysc  <= '0;
    end else if (p1_end_of_frame) begin
      act_addr <= sh_addr;
      act_x1   <= sh_x1;
      act_y1   <= sh_y1;
      act_x2   <= sh_x2;
      act_y2   <= sh_y2;
      act_bpl  <= sh_bpl;
      act_bpp  <= sh_bpp;
      act_en   <= sh_en;
      act_xsc  <= sh_xsc;
      act_ysc  <= sh_ysc;
    end
  end

  assign x_in     = (p1_x >= act_x1) && (p1_x < act_x2);
  assign y_in     = (p1_y >= act_y1) && (p1_y < act_y2);
  assign hit      = act_en && x_in && y_in;
  assign line_adv = line_start + ADDR_W'(act_bpl);
  assign pix_adv  = pix_next + ADDR_W'(act_bpp);

  // End of line inside the Y range always rewinds to a line start, even when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p2_addr    <= '0;
      p2_valid   <= 1'b0;
      line_start <= '0;
      pix_next   <= '0;
      xrep       <= '0;
      yrep       <= '0;
    end else if (p1_end_of_frame) begin
      line_start <= sh_addr;
      pix_next   <= sh_addr;
      xrep       <= '0;
      yrep       <= '0;
      p2_valid   <= 1'b0;
    end else if (!stall) begin
      if (!p1_valid) begin
        p2_valid <= 1'b0;
      end else begin
        p2_addr  <= pix_next;
        p2_valid <= hit;
        if (p1_end_of_line && y_in) begin
          xrep <= '0;
          if (yrep == act_ysc) begin
            yrep       <= '0;
            line_start <= line_adv;
            pix_next   <= line_adv;
          end else begin
            yrep     <= yrep + 3'd1;
            pix_next <= line_start;
          end
        end else if (hit) begin
          if (xrep == act_xsc) begin
            xrep     <= '0;
            pix_next <= pix_adv;
          end else begin
            xrep <= xrep + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_layer_scaled.sv
// Randomised bench for vga_layer_scaled; expected addresses come from a closed-form
// model: ADDR + (lines/yscale)*BPL + (hits/xscale)*BPP, modulo 2^ADDR_W.
module tb_vga_layer_scaled;
  localparam int ADDR_W  = 26;
  localparam int COORD_W = 11;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               stall = 1'b0;
  logic               sel = 1'b0;
  logic [2:0]         raddr = '0;
  logic [ADDR_W-1:0]  wdata = '0;
  logic               valid = 1'b0;
  logic [COORD_W-1:0] x = '0, y = '0;
  logic               eof = 1'b0, eol = 1'b0;
  logic [ADDR_W-1:0]  p2_addr;
  logic               p2_valid;

  logic [ADDR_W-1:0]  sh [8];
  logic [ADDR_W-1:0]  act [8];
  logic [ADDR_W-1:0]  exp_addr;
  logic               exp_valid;
  int                 m_lines, m_hits;
  int                 n_cmp = 0, n_fail = 0;

  vga_layer_scaled #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .hwregs_layer_select(sel), .hwregs_layer_addr(raddr), .hwregs_wdata(wdata),
    .p1_valid(valid), .p1_x(x), .p1_y(y),
    .p1_end_of_frame(eof), .p1_end_of_line(eol),
    .p2_addr(p2_addr), .p2_valid(p2_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] field_mask(input logic [2:0] a);
    case (a)
      3'd0:    return '1;
      3'd6:    return ADDR_W'(3);
      3'd7:    return ADDR_W'(127);
      default: return ADDR_W'((1 << COORD_W) - 1);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sh[i] = '0;
      act[i] = '0;
    end
    exp_addr = '0; exp_valid = 1'b0; m_lines = 0; m_hits = 0;
  endtask

  // Update the reference model from the inputs presented this cycle, then clock.
  task automatic tick();
    int  xs, ys;
    logic in_y, hit;
    xs   = int'(act[7][3:1]) + 1;
    ys   = int'(act[7][6:4]) + 1;
    in_y = (int'(y) >= int'(act[2])) && (int'(y) < int'(act[4]));
    hit  = act[7][0] && in_y && (int'(x) >= int'(act[1])) && (int'(x) < int'(act[3]));
    if (eof) begin
      for (int i = 0; i < 8; i++) act[i] = sh[i];
      m_lines = 0; m_hits = 0; exp_valid = 1'b0;
    end else if (!stall) begin
      if (!valid) exp_valid = 1'b0;
      else begin
        exp_addr  = ADDR_W'(longint'(act[0]) + longint'(m_lines / ys) * longint'(act[5])
                            + longint'(m_hits / xs) * longint'(act[6]));
        exp_valid = hit;
        if (eol && in_y) begin m_lines++; m_hits = 0; end
        else if (hit) m_hits++;
      end
    end
    if (sel) sh[raddr] = wdata & field_mask(raddr);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [ADDR_W-1:0] d);
    sel = 1'b1; raddr = a; wdata = d; valid = 1'b0;
    tick();
    sel = 1'b0;
  endtask

  task automatic program_layer(input logic [ADDR_W-1:0] base, input int x1, y1, x2, y2,
                               input int bpl, bpp, ctrl);
    wr(3'd0, base);
    wr(3'd1, ADDR_W'(x1)); wr(3'd2, ADDR_W'(y1));
    wr(3'd3, ADDR_W'(x2)); wr(3'd4, ADDR_W'(y2));
    wr(3'd5, ADDR_W'(bpl)); wr(3'd6, ADDR_W'(bpp)); wr(3'd7, ADDR_W'(ctrl));
  endtask

  task automatic end_frame();
    eof = 1'b1; valid = 1'b0;
    tick();
    eof = 1'b0;
  endtask

  task automatic pix(input int px, input int py, input logic last);
    valid = 1'b1; x = COORD_W'(px); y = COORD_W'(py); eol = last;
    tick();
    valid = 1'b0; eol = 1'b0;
  endtask

  // Raster scan of a w x h screen with optional idle gaps and stall cycles.
  task automatic run_frame(input string tag, input int w, input int h,
                           input int gap_pct, input int stall_pct);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        if (int'($urandom_range(0, 99)) < gap_pct) begin
          valid = 1'b0;
          tick();
          n_cmp++;
          if ({p2_valid, p2_addr} !== {exp_valid, exp_addr}) begin
            n_fail++;
            $display("[TB] FAIL %s gap y%0d x%0d: got v=%0b a=%h, want v=%0b a=%h",
                     tag, yy, xx, p2_valid, p2_addr, exp_valid, exp_addr);
          end
        end
        if (int'($urandom_range(0, 99)) < stall_pct) begin
          stall = 1'b1; valid = 1'($urandom_range(0, 1));
          x = COORD_W'($urandom_range(0, w - 1)); eol = 1'($urandom_range(0, 1));
          tick();
          stall = 1'b0; eol = 1'b0;
          n_cmp++;
          if ({p2_valid, p2_addr} !== {exp_valid, exp_addr}) begin
            n_fail++;
            $display("[TB] FAIL %s stall y%0d x%0d: got v=%0b a=%h, want v=%0b a=%h",
                     tag, yy, xx, p2_valid, p2_addr, exp_valid, exp_addr);
          end
        end
        pix(xx, yy, xx == w - 1);
        n_cmp++;
        if ({p2_valid, p2_addr} !== {exp_valid, exp_addr}) begin
          n_fail++;
          $display("[TB] FAIL %s pixel y%0d x%0d: got v=%0b a=%h, want v=%0b a=%h",
                   tag, yy, xx, p2_valid, p2_addr, exp_valid, exp_addr);
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (p2_valid !== 1'b0 || p2_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got v=%0b a=%h, want v=0 a=0", p2_valid, p2_addr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame("reset_idle", 4, 2, 0, 0);
  endtask

  task automatic test_scale1();
    program_layer(26'h1000, 0, 0, 4, 2, 8, 2, 1);
    end_frame();
    pix(0, 0, 1'b0);
    pix(1, 0, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_addr !== 26'h1002) begin
      n_fail++;
      $display("[TB] FAIL scale1_second: got v=%0b a=%h, want v=1 a=1002", p2_valid, p2_addr);
    end
    end_frame();
    run_frame("scale1", 6, 3, 0, 0);
  endtask

  task automatic test_scale2();
    program_layer(26'h1000, 0, 0, 4, 4, 8, 2, 32'h13);
    end_frame();
    run_frame("scale2x2", 6, 4, 0, 0);
    end_frame();
    pix(0, 0, 1'b1); pix(0, 1, 1'b1); pix(0, 2, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_addr !== 26'h1008) begin
      n_fail++;
      $display("[TB] FAIL scale2_line2: got v=%0b a=%h, want v=1 a=1008", p2_valid, p2_addr);
    end
  endtask

  task automatic test_shadow();
    program_layer(26'h1000, 0, 0, 4, 2, 8, 2, 1);
    end_frame();
    pix(0, 0, 1'b0);
    sel = 1'b1; raddr = 3'd0; wdata = 26'h2000;
    pix(1, 0, 1'b0);
    sel = 1'b0;
    n_cmp++;
    if (p2_addr !== 26'h1002) begin
      n_fail++;
      $display("[TB] FAIL shadow_midframe: got a=%h, want a=1002", p2_addr);
    end
    run_frame("shadow_old", 6, 2, 0, 0);
    sel = 1'b1; raddr = 3'd0; wdata = 26'h3000;
    end_frame();
    sel = 1'b0;
    pix(0, 0, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_addr !== 26'h2000) begin
      n_fail++;
      $display("[TB] FAIL shadow_eof_write: got v=%0b a=%h, want v=1 a=2000", p2_valid, p2_addr);
    end
    run_frame("shadow_2000", 6, 2, 0, 0);
    end_frame();
    run_frame("shadow_3000", 6, 2, 0, 0);
  endtask

  task automatic test_stall();
    program_layer(26'h1000, 0, 0, 4, 4, 8, 2, 32'h13);
    end_frame();
    for (int yy = 0; yy < 3; yy++) begin
      for (int xx = 0; xx < 6; xx++) begin
        if (xx == 1) begin
          for (int s = 0; s < 3; s++) begin
            stall = 1'b1; valid = 1'b1; x = COORD_W'(xx + s); y = COORD_W'(yy);
            tick();
            n_cmp++;
            if ({p2_valid, p2_addr} !== {exp_valid, exp_addr}) begin
              n_fail++;
              $display("[TB] FAIL stall_hold y%0d s%0d: got v=%0b a=%h, want v=%0b a=%h",
                       yy, s, p2_valid, p2_addr, exp_valid, exp_addr);
            end
          end
          stall = 1'b0;
        end
        pix(xx, yy, xx == 5);
        n_cmp++;
        if ({p2_valid, p2_addr} !== {exp_valid, exp_addr}) begin
          n_fail++;
          $display("[TB] FAIL stall_resume y%0d x%0d: got v=%0b a=%h, want v=%0b a=%h",
                   yy, xx, p2_valid, p2_addr, exp_valid, exp_addr);
        end
      end
    end
    wr(3'd0, 26'h4000);
    stall = 1'b1;
    end_frame();
    n_cmp++;
    if (p2_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_eof_valid: got v=%0b, want v=0", p2_valid);
    end
    stall = 1'b0;
    pix(0, 0, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_addr !== 26'h4000) begin
      n_fail++;
      $display("[TB] FAIL stall_eof_reload: got v=%0b a=%h, want v=1 a=4000", p2_valid, p2_addr);
    end
  endtask

  task automatic test_wrap_disable();
    program_layer(26'h3FFFFFE, 0, 0, 4, 2, 8, 2, 1);
    end_frame();
    pix(0, 0, 1'b0);
    pix(1, 0, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b1 || p2_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL wrap_second: got v=%0b a=%h, want v=1 a=0", p2_valid, p2_addr);
    end
    wr(3'd7, 26'h0);
    end_frame();
    pix(0, 0, 1'b1);
    pix(0, 1, 1'b0);
    n_cmp++;
    if (p2_valid !== 1'b0 || p2_addr !== 26'h6) begin
      n_fail++;
      $display("[TB] FAIL disable_line_adv: got v=%0b a=%h, want v=0 a=6", p2_valid, p2_addr);
    end
    end_frame();
    run_frame("disabled", 6, 3, 10, 10);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      program_layer(ADDR_W'($urandom), $urandom_range(0, 8), $urandom_range(0, 4),
                    $urandom_range(0, 16), $urandom_range(0, 8), $urandom_range(0, 2047),
                    $urandom_range(0, 3), int'($urandom_range(0, 127)) | (f < 5 ? 1 : 0));
      end_frame();
      run_frame("random", 16, 8, 15, 15);
    end
  endtask

  task automatic test_async_reset();
    program_layer(26'h1000, 0, 0, 4, 2, 8, 2, 1);
    end_frame();
    pix(0, 0, 1'b0);
    pix(1, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (p2_valid !== 1'b0 || p2_addr !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got v=%0b a=%h, want v=0 a=0", p2_valid, p2_addr);
    end
    model_reset();
    #3 reset = 1'b1;
    run_frame("post_reset", 6, 2, 0, 0);
    end_frame();
    run_frame("post_reset_eof", 6, 2, 0, 0);
    program_layer(26'h1000, 0, 0, 4, 2, 8, 2, 1);
    run_frame("reprog_no_eof", 6, 2, 0, 0);
    end_frame();
    run_frame("reprog_eof", 6, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_scale1();
    test_scale2();
    test_shadow();
    test_stall();
    test_wrap_disable();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_scaled.md
# vga_layer_scaled

Parametrised next-generation VGA layer address generator for the pixel pipeline. It holds one rectangular layer's configuration, programmed through the write-only hwregs bus. For every pipeline pixel it produces the framebuffer byte address and a hit flag. Over the fixed single-layer generator it adds configurable address/coordinate widths, integer pixel replication (1–8× in X and Y independently), a layer enable bit, and shadowed registers that take effect only at end of frame, so software updates never tear mid-frame.

## Interface
Parameters:
- ADDR_W, 26, framebuffer byte-address width
- COORD_W, 11, pixel coordinate and bytes-per-line width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- stall  in  1  pipeline hold; all state frozen except shadow writes and end-of-frame load
- hwregs_layer_select  in  1  register write strobe
- hwregs_layer_addr  in  3  register index
- hwregs_wdata  in  ADDR_W  write data
- p1_valid  in  1  pixel slot valid
- p1_x, p1_y  in  COORD_W  current screen coordinate
- p1_end_of_frame  in  1  frame boundary; not a pixel
- p1_end_of_line  in  1  qualifies the last valid pixel of a line
- p2_addr  out  ADDR_W  byte address of layer pixel
- p2_valid  out  1  pixel lies inside an enabled layer

## Operation
- Shadow register map (writes land in shadow set on select):
  - 0: ADDR[ADDR_W-1:0]
  - 1: X1
  - 2: Y1
  - 3: X2 (exclusive)
  - 4: Y2 (exclusive)
  - 5: BPL[COORD_W-1:0]
  - 6: BPP[1:0]
  - 7: CTRL, where [0]=enable, [3:1]=xscale-1, [6:4]=yscale-1
  - Unused bits are ignored.
- Active set loads from shadow on a p1_end_of_frame cycle. The load takes the shadow value present before any same-cycle write, so that write applies from the following frame.
- The hit test uses the active set: hit = enable && X1≤x<X2 && Y1≤y<Y2.
- Internal state:
  - line_start: address of the current source line
  - pix_next: address of the next pixel
  - xrep: count 0..xscale-1
  - yrep: count 0..yscale-1
- Priority per cycle: end_of_frame > stall > !p1_valid > pixel.
  - end_of_frame: line_start and pix_next take the new active ADDR; xrep and yrep clear; p2_valid is 0. This applies even while stall is high.
  - stall: hold all outputs and state.
  - !p1_valid: p2_valid is 0; p2_addr holds its value.
  - pixel:
    - p2_addr takes pix_next; p2_valid takes hit.
    - If hit: when xrep==xscale-1, xrep clears and pix_next += BPP; otherwise xrep increments.
    - If end_of_line and Y1≤y<Y2 (enable ignored), this overrides the X update. xrep clears.
    - When yrep==yscale-1: yrep clears, line_start += BPL, pix_next takes line_start+BPL.
    - Otherwise: yrep increments and pix_next takes line_start (the source line repeats).
- Arithmetic: all address sums are zero-extended and wrap modulo 2^ADDR_W. BPP=0 is legal and repeats the same address.
- Empty windows (X1≥X2 or Y1≥Y2) never hit.

## Timing
- One-cycle latency: p1 pixel at edge N gives p2_addr/p2_valid after edge N.
- Register write to active: effective at the first end_of_frame strictly after the write cycle.
- Reset (asynchronous, level 0): every shadow and active register clears, giving enable 0 and 1× scale. p2_valid, p2_addr, pix_next, line_start, xrep and yrep all clear.
- Reset mid-frame: outputs are 0 immediately. Hits resume only after software re-programs the layer and an end_of_frame arrives.
- Stall applied mid-replication freezes xrep and yrep. Resuming continues exactly where it stopped.

## Test plan
- 1× scale: ADDR=0x1000, window (0,0)-(4,2), BPL=8, BPP=2, enable. After end_of_frame, the expected addresses are:
  - line 0: 0x1000, 0x1002, 0x1004, 0x1006
  - line 1: 0x1008 through 0x100E
  - p2_valid is 0 outside the window.
- 2×2 scale: same setup with CTRL xscale-1=1, yscale-1=1. Line 0 gives 0x1000, 0x1000, 0x1002, 0x1002. Line 1 repeats line 0. Line 2 starts at 0x1008.
- Shadowing: write ADDR=0x2000 mid-frame. Outputs stay based on 0x1000 until the next end_of_frame, then line 0 starts at 0x2000. Also write on the end_of_frame cycle itself; the value applies only from the following frame.
- Stall: assert stall for 3 cycles during 2× replication. p2 is held and the sequence resumes without skipping or duplicating addresses. end_of_frame under stall still reloads ADDR.
- Wrap and disable:
  - With ADDR=2^ADDR_W−2 and BPP=2, the second pixel address is 0.
  - With enable=0, p2_valid stays 0, yet line advance still occurs on in-Y end_of_line.
- Async reset: drop reset mid-line. p2_valid and p2_addr go to 0 without a clock edge. After release, hits stay absent until reprogramming and end_of_frame.
